// File: rtl/rf_access_pkg.sv
// Shared sizes and types for the register-file access controller.
// lane_gate zeroes the lanes of a packed vector whose mask bit is clear.
package rf_access_pkg;

   localparam int NUM_LANES  = 16;
   localparam int NUM_REGS   = 64;
   localparam int DATA_W     = 32;
   localparam int NUM_WARPS  = 16;
   localparam int STARVE_MAX = 4;
   localparam int AW         = $clog2(NUM_REGS);
   localparam int WW         = $clog2(NUM_WARPS);
   localparam int SW         = $clog2(STARVE_MAX + 1);

   typedef logic [NUM_LANES*DATA_W-1:0] lane_vec_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_READ,
      GNT_WRITE
   } grant_e;

   function automatic lane_vec_t lane_gate(
      input lane_vec_t            d,
      input logic [NUM_LANES-1:0] m
   );
      lane_vec_t v;
      v = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (m[l]) v[DATA_W*l +: DATA_W] = d[DATA_W*l +: DATA_W];
      end
      return v;
   endfunction

endpackage

// File: rtl/rf_access_arb.sv
// One-grant-per-cycle arbiter between writeback and issue for the RF port.
// Writeback wins unless an eligible issue has starved too long.
module rf_access_arb
   import rf_access_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          iss_valid,
   input  logic [WW-1:0] iss_warp,
   input  logic [AW-1:0] iss_src0,
   input  logic [AW-1:0] iss_src1,
   input  logic          iss_use0,
   input  logic          iss_use1,
   input  logic          wb_valid,
   input  logic [WW-1:0] wb_warp,
   input  logic [AW-1:0] wb_addr,
   input  logic          slot_free,
   output grant_e        grant
);

   logic [SW-1:0] r_starve_cnt;
   logic          w_iss_elig;
   logic          w_hazard;
   logic          w_override;

   assign w_iss_elig = iss_valid && slot_free;

   assign w_hazard = wb_valid && iss_valid && (wb_warp == iss_warp) &&
                     ((iss_use0 && (wb_addr == iss_src0)) ||
                      (iss_use1 && (wb_addr == iss_src1)));

   // A pending write to a source register must land before the read.
   assign w_override = (r_starve_cnt == SW'(STARVE_MAX)) &&
                       w_iss_elig && !w_hazard;

   always_comb begin
      grant = GNT_NONE;
      if (!rst_n) begin
         grant = GNT_NONE;
      end else if (wb_valid && !w_override) begin
         grant = GNT_WRITE;
      end else if (w_iss_elig) begin
         grant = GNT_READ;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (!w_iss_elig || (grant == GNT_READ)) begin
         r_starve_cnt <= '0;
      end else if ((grant == GNT_WRITE) &&
                   (r_starve_cnt != SW'(STARVE_MAX))) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/register_access_ctrl.sv
// Drives register_block on behalf of issue and writeback, one access a cycle.
// Read data lands in a one-entry operand register toward the execute lanes.
module register_access_ctrl
   import rf_access_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        iss_valid,
   output logic                        iss_ready,
   input  logic [WW-1:0]               iss_warp,
   input  logic [NUM_LANES-1:0]        iss_mask,
   input  logic [AW-1:0]               iss_src0,
   input  logic [AW-1:0]               iss_src1,
   input  logic                        iss_use0,
   input  logic                        iss_use1,
   input  logic                        wb_valid,
   output logic                        wb_ready,
   input  logic [WW-1:0]               wb_warp,
   input  logic [NUM_LANES-1:0]        wb_mask,
   input  logic [AW-1:0]               wb_addr,
   input  logic [NUM_LANES*DATA_W-1:0] wb_data,
   output logic                        opd_valid,
   input  logic                        opd_ready,
   output logic [WW-1:0]               opd_warp,
   output logic [NUM_LANES-1:0]        opd_mask,
   output logic [NUM_LANES*DATA_W-1:0] opd_a,
   output logic [NUM_LANES*DATA_W-1:0] opd_b,
   output logic [NUM_LANES-1:0]        rf_read_en_0,
   output logic [NUM_LANES-1:0]        rf_read_en_1,
   output logic [AW-1:0]               rf_raddr_0,
   output logic [AW-1:0]               rf_raddr_1,
   output logic [NUM_LANES-1:0]        rf_write_en,
   output logic [AW-1:0]               rf_waddr,
   output logic [NUM_LANES*DATA_W-1:0] rf_wdata,
   output logic [WW-1:0]               rf_warp_selector,
   input  logic [NUM_LANES*DATA_W-1:0] rf_rdata_0,
   input  logic [NUM_LANES*DATA_W-1:0] rf_rdata_1
);

   grant_e               w_grant;
   logic                 w_rd;
   logic                 w_wr;
   logic                 w_slot_free;
   logic                 r_opd_valid;
   logic [WW-1:0]        r_opd_warp;
   logic [NUM_LANES-1:0] r_opd_mask;
   lane_vec_t            r_opd_a;
   lane_vec_t            r_opd_b;

   assign w_slot_free = !r_opd_valid || opd_ready;

   rf_access_arb u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_valid (iss_valid),
      .iss_warp  (iss_warp),
      .iss_src0  (iss_src0),
      .iss_src1  (iss_src1),
      .iss_use0  (iss_use0),
      .iss_use1  (iss_use1),
      .wb_valid  (wb_valid),
      .wb_warp   (wb_warp),
      .wb_addr   (wb_addr),
      .slot_free (w_slot_free),
      .grant     (w_grant)
   );

   assign w_rd = (w_grant == GNT_READ);
   assign w_wr = (w_grant == GNT_WRITE);

   assign iss_ready = w_rd;
   assign wb_ready  = w_wr;

   assign rf_warp_selector = w_wr ? wb_warp : (w_rd ? iss_warp : '0);
   assign rf_read_en_0     = (w_rd && iss_use0) ? iss_mask : '0;
   assign rf_read_en_1     = (w_rd && iss_use1) ? iss_mask : '0;
   assign rf_raddr_0       = w_rd ? iss_src0 : '0;
   assign rf_raddr_1       = w_rd ? iss_src1 : '0;
   assign rf_write_en      = w_wr ? wb_mask : '0;
   assign rf_waddr         = w_wr ? wb_addr : '0;
   assign rf_wdata         = w_wr ? wb_data : '0;

   // Read enables already carry use/mask, so they double as the lane gate.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_opd_valid <= 1'b0;
         r_opd_warp  <= '0;
         r_opd_mask  <= '0;
         r_opd_a     <= '0;
         r_opd_b     <= '0;
      end else if (w_rd) begin
         r_opd_valid <= 1'b1;
         r_opd_warp  <= iss_warp;
         r_opd_mask  <= iss_mask;
         r_opd_a     <= lane_gate(rf_rdata_0, rf_read_en_0);
         r_opd_b     <= lane_gate(rf_rdata_1, rf_read_en_1);
      end else if (opd_ready) begin
         r_opd_valid <= 1'b0;
      end
   end

   assign opd_valid = r_opd_valid;
   assign opd_warp  = r_opd_warp;
   assign opd_mask  = r_opd_mask;
   assign opd_a     = r_opd_a;
   assign opd_b     = r_opd_b;

endmodule

// File: tb/tb_register_access_ctrl.sv
// Directed bench for register_access_ctrl.
// Behavioural RF model plus operand scoreboard.
module tb_register_access_ctrl;
  import rf_access_pkg::*;

  localparam logic [NUM_LANES-1:0] FULL = 16'hFFFF;
  localparam int CW = NUM_LANES*DATA_W;

  logic                 clk;
  logic                 rst_n;
  logic                 iss_valid, iss_ready;
  logic [WW-1:0]        iss_warp;
  logic [NUM_LANES-1:0] iss_mask;
  logic [AW-1:0]        iss_src0, iss_src1;
  logic                 iss_use0, iss_use1;
  logic                 wb_valid, wb_ready;
  logic [WW-1:0]        wb_warp;
  logic [NUM_LANES-1:0] wb_mask;
  logic [AW-1:0]        wb_addr;
  lane_vec_t            wb_data;
  logic                 opd_valid, opd_ready;
  logic [WW-1:0]        opd_warp;
  logic [NUM_LANES-1:0] opd_mask;
  lane_vec_t            opd_a, opd_b;
  logic [NUM_LANES-1:0] rf_read_en_0;
  logic [NUM_LANES-1:0] rf_read_en_1;
  logic [NUM_LANES-1:0] rf_write_en;
  logic [AW-1:0]        rf_raddr_0, rf_raddr_1;
  logic [AW-1:0]        rf_waddr;
  lane_vec_t            rf_wdata;
  lane_vec_t            rf_rdata_0, rf_rdata_1;
  logic [WW-1:0]        rf_warp_selector;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [WW-1:0]        warp;
    logic [NUM_LANES-1:0] mask;
    lane_vec_t            a;
    lane_vec_t            b;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  register_access_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .iss_valid        (iss_valid),
    .iss_ready        (iss_ready),
    .iss_warp         (iss_warp),
    .iss_mask         (iss_mask),
    .iss_src0         (iss_src0),
    .iss_src1         (iss_src1),
    .iss_use0         (iss_use0),
    .iss_use1         (iss_use1),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_warp          (wb_warp),
    .wb_mask          (wb_mask),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .opd_valid        (opd_valid),
    .opd_ready        (opd_ready),
    .opd_warp         (opd_warp),
    .opd_mask         (opd_mask),
    .opd_a            (opd_a),
    .opd_b            (opd_b),
    .rf_read_en_0     (rf_read_en_0),
    .rf_read_en_1     (rf_read_en_1),
    .rf_raddr_0       (rf_raddr_0),
    .rf_raddr_1       (rf_raddr_1),
    .rf_write_en      (rf_write_en),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .rf_warp_selector (rf_warp_selector),
    .rf_rdata_0       (rf_rdata_0),
    .rf_rdata_1       (rf_rdata_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    bad++;
    $error("FAIL timeout: bench did not finish");
    $finish;
  end

  task automatic chk(string t,
                     logic [CW-1:0] o,
                     logic [CW-1:0] e);
    total++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", t, o, e);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(
    int w, int r, int l);
    return 32'hA000_0000 + 32'(w << 16) +
           32'(r << 8) + 32'(l);
  endfunction

  function automatic lane_vec_t ramp(
    logic [31:0] base,
    logic [NUM_LANES-1:0] m);
    lane_vec_t v;
    v = '0;
    for (int l = 0; l < NUM_LANES; l++)
      if (m[l]) v[DATA_W*l +: DATA_W] = base + 32'(l);
    return v;
  endfunction

  function automatic lane_vec_t patv(int w, int r);
    lane_vec_t v;
    v = '0;
    for (int l = 0; l < NUM_LANES; l++)
      v[DATA_W*l +: DATA_W] = pat(w, r, l);
    return v;
  endfunction

  function automatic exp_t mk(
    int w, logic [NUM_LANES-1:0] m,
    lane_vec_t a, lane_vec_t b);
    exp_t e;
    e.warp = WW'(w);
    e.mask = m;
    e.a    = a;
    e.b    = b;
    return e;
  endfunction

  logic [DATA_W-1:0] mem [NUM_WARPS][NUM_REGS][NUM_LANES];
  logic              model_clr;

  always @(posedge clk) begin
    if (model_clr) begin
      for (int w = 0; w < NUM_WARPS; w++)
        for (int r = 0; r < NUM_REGS; r++)
          for (int l = 0; l < NUM_LANES; l++)
            mem[w][r][l] <= pat(w, r, l);
    end else begin
      for (int l = 0; l < NUM_LANES; l++)
        if (rf_write_en[l])
          mem[rf_warp_selector][rf_waddr][l] <=
            rf_wdata[DATA_W*l +: DATA_W];
    end
  end

  always_comb begin
    rf_rdata_0 = '0;
    rf_rdata_1 = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      rf_rdata_0[DATA_W*l +: DATA_W] =
        rf_read_en_0[l] ?
        mem[rf_warp_selector][rf_raddr_0][l] :
        32'hBAD0_0000;
      rf_rdata_1[DATA_W*l +: DATA_W] =
        rf_read_en_1[l] ?
        mem[rf_warp_selector][rf_raddr_1][l] :
        32'hBAD1_0000;
    end
  end

  always @(negedge clk) begin
    if (rst_n && opd_valid && opd_ready) begin
      chk("sb_nonempty", (sbq.size() != 0), 1'b1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("opd_warp", opd_warp, mon_e.warp);
        chk("opd_mask", opd_mask, mon_e.mask);
        chk("opd_a", opd_a, mon_e.a);
        chk("opd_b", opd_b, mon_e.b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    iss_warp  = '0;
    iss_mask  = '0;
    iss_src0  = '0;
    iss_src1  = '0;
    iss_use0  = 1'b0;
    iss_use1  = 1'b0;
    wb_valid  = 1'b0;
    wb_warp   = '0;
    wb_mask   = '0;
    wb_addr   = '0;
    wb_data   = '0;
  endtask

  task automatic set_wb(int w, int a,
                        logic [31:0] base);
    wb_valid = 1'b1;
    wb_warp  = WW'(w);
    wb_addr  = AW'(a);
    wb_mask  = FULL;
    wb_data  = ramp(base, FULL);
  endtask

  task automatic set_iss(
    int w, int s0, int s1,
    logic u0, logic u1,
    logic [NUM_LANES-1:0] m);
    iss_valid = 1'b1;
    iss_warp  = WW'(w);
    iss_src0  = AW'(s0);
    iss_src1  = AW'(s1);
    iss_use0  = u0;
    iss_use1  = u1;
    iss_mask  = m;
  endtask

  task automatic run_starve(int nw, exp_t e);
    for (int c = 0; c <= nw; c++) begin
      @(negedge clk);
      chk("stv_wb_ready", wb_ready, (c < nw));
      chk("stv_iss_ready", iss_ready, (c == nw));
      if (c == nw) sbq.push_back(e);
      step();
    end
  endtask

  initial begin
    idle();
    opd_ready = 1'b0;
    rst_n     = 1'b0;
    model_clr = 1'b1;
    set_wb(3, 'h2A, 32'h1111_0000);
    set_iss(3, 'h2A, 'h2A, 1'b1, 1'b1, FULL);
    step();
    model_clr = 1'b0;
    @(negedge clk);
    chk("rst_wb_ready", wb_ready, 1'b0);
    chk("rst_iss_ready", iss_ready, 1'b0);
    chk("rst_wen", rf_write_en, 16'h0000);
    chk("rst_ren0", rf_read_en_0, 16'h0000);
    chk("rst_sel", rf_warp_selector, 4'h0);
    chk("rst_opd_valid", opd_valid, 1'b0);
    chk("rst_opd_mask", opd_mask, 16'h0000);
    chk("rst_opd_a", opd_a, lane_vec_t'(0));
    step();
    rst_n     = 1'b1;
    idle();
    opd_ready = 1'b1;

    set_wb(3, 'h2A, 32'h0000_1000);
    @(negedge clk);
    chk("wr_wb_ready", wb_ready, 1'b1);
    chk("wr_iss_ready", iss_ready, 1'b0);
    chk("wr_wen", rf_write_en, FULL);
    chk("wr_sel", rf_warp_selector, 4'h3);
    chk("wr_waddr", rf_waddr, 6'h2A);
    step();
    idle();
    set_iss(3, 'h2A, 'h2A, 1'b1, 1'b1, FULL);
    sbq.push_back(mk(3, FULL, ramp(32'h1000, FULL),
                     ramp(32'h1000, FULL)));
    @(negedge clk);
    chk("rd_iss_ready", iss_ready, 1'b1);
    chk("rd_ren1", rf_read_en_1, FULL);
    chk("rd_raddr0", rf_raddr_0, 6'h2A);
    chk("rd_wen", rf_write_en, 16'h0000);
    step();
    idle();
    @(negedge clk);
    chk("lat_valid", opd_valid, 1'b1);
    step();
    @(negedge clk);
    chk("drain_valid", opd_valid, 1'b0);

    set_wb(5, 'h07, 32'hDEAD_0000);
    set_iss(5, 'h07, 'h00, 1'b1, 1'b0, FULL);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("hz_wb_ready", wb_ready, 1'b1);
      chk("hz_iss_ready", iss_ready, 1'b0);
      step();
    end
    wb_valid = 1'b0;
    sbq.push_back(mk(5, FULL, ramp(32'hDEAD_0000, FULL),
                     lane_vec_t'(0)));
    @(negedge clk);
    chk("hz_rd_grant", iss_ready, 1'b1);
    step();
    idle();
    step();

    set_wb(1, 'h10, 32'h0000_5000);
    set_iss(2, 'h11, 'h00, 1'b1, 1'b0, FULL);
    run_starve(4, mk(2, FULL, patv(2, 'h11),
                     lane_vec_t'(0)));
    iss_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stv_resume", wb_ready, 1'b1);
      step();
    end
    idle();

    opd_ready = 1'b0;
    set_iss(3, 'h2A, 'h00, 1'b1, 1'b0, FULL);
    sbq.push_back(mk(3, FULL, ramp(32'h1000, FULL),
                     lane_vec_t'(0)));
    @(negedge clk);
    chk("bp_first", iss_ready, 1'b1);
    step();
    set_iss(1, 'h10, 'h10, 1'b1, 1'b1, FULL);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_iss_ready", iss_ready, 1'b0);
      chk("bp_ren0", rf_read_en_0, 16'h0000);
      chk("bp_ren1", rf_read_en_1, 16'h0000);
      chk("bp_hold_a", opd_a, ramp(32'h1000, FULL));
      step();
    end
    opd_ready = 1'b1;
    sbq.push_back(mk(1, FULL, ramp(32'h5000, FULL),
                     ramp(32'h5000, FULL)));
    @(negedge clk);
    chk("bp_release", iss_ready, 1'b1);
    step();
    idle();
    step();

    set_iss(3, 'h2A, 'h10, 1'b1, 1'b0, 16'h00FF);
    sbq.push_back(mk(3, 16'h00FF,
                     ramp(32'h1000, 16'h00FF),
                     lane_vec_t'(0)));
    @(negedge clk);
    chk("mask_ren0", rf_read_en_0, 16'h00FF);
    chk("mask_ren1", rf_read_en_1, 16'h0000);
    step();
    idle();
    step();

    set_wb(1, 'h10, 32'h0000_6000);
    set_iss(2, 'h11, 'h00, 1'b1, 1'b0, FULL);
    for (int c = 0; c < 3; c++) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rs_wen", rf_write_en, 16'h0000);
    chk("rs_wb_ready", wb_ready, 1'b0);
    step();
    rst_n = 1'b1;
    run_starve(4, mk(2, FULL, patv(2, 'h11),
                     lane_vec_t'(0)));
    idle();
    step();

    opd_ready = 1'b0;
    set_iss(4, 'h03, 'h03, 1'b1, 1'b1, FULL);
    step();
    idle();
    set_wb(4, 'h03, 32'h0000_7000);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rs2_opd_valid", opd_valid, 1'b1);
    chk("rs2_wen", rf_write_en, 16'h0000);
    step();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("rs2_cleared", opd_valid, 1'b0);
    chk("rs2_opd_a", opd_a, lane_vec_t'(0));
    chk("rs2_opd_mask", opd_mask, 16'h0000);
    opd_ready = 1'b1;
    step();
    set_iss(4, 'h03, 'h00, 1'b1, 1'b0, FULL);
    sbq.push_back(mk(4, FULL, patv(4, 'h03),
                     lane_vec_t'(0)));
    step();
    idle();
    step();
    step();

    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
